// File: rtl/decode_stage.sv
// Decode stage: register file with write-through, per-operand forwarding and
// load-use hazard detection, feeding a single-entry valid/ready output register.

module decode_fwd #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [AW-1:0]   addr,
    input  logic            use_op,
    input  logic            ex_wr_en,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_wr_en,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wr_en,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] value,
    output logic            hazard
);
    logic nz, ex_hit, mem_hit, wb_hit;

    always_comb begin
        nz      = (addr != '0);
        ex_hit  = nz && ex_wr_en  && (ex_waddr  == addr);
        mem_hit = nz && mem_wr_en && (mem_waddr == addr);
        wb_hit  = nz && wb_wr_en  && (wb_waddr  == addr);
        // WB write-through belongs to the register file, so it applies in both modes
        value = wb_hit ? wb_wdata : rf_data;
        if (FWD_EN) begin
            if (ex_hit && !ex_is_load) value = ex_result;
            else if (mem_hit)          value = mem_result;
        end
        hazard = use_op && ((ex_hit && ex_is_load) ||
                            (!FWD_EN && (ex_hit || mem_hit || wb_hit)));
    end
endmodule

module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit FWD_EN = 1'b1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [15:0]     imm16,
    input  logic            sext,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            rd_or_rt,
    input  logic            wr_en_in,
    input  logic            is_load_in,
    input  logic            ex_wr_en,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_wr_en,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wr_en,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_da,
    output logic [XLEN-1:0] out_db,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rn,
    output logic            out_wr_en,
    output logic            out_is_load,
    output logic            out_rs_eq_rt,
    output logic            stall
);
    logic [XLEN-1:0]            rf [NREG];
    logic [1:0][AW-1:0]         src_addr;
    logic [1:0]                 src_use;
    logic [1:0][XLEN-1:0]       opnd;
    logic [1:0]                 hz;
    logic                       hazard, accept;

    assign src_addr = {rt_addr, rs_addr};
    assign src_use  = {use_rt, use_rs};

    for (genvar g = 0; g < 2; g++) begin : g_op
        decode_fwd #(.XLEN(XLEN), .AW(AW), .FWD_EN(FWD_EN)) u_fwd (
            .addr(src_addr[g]), .use_op(src_use[g]),
            .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
            .ex_waddr(ex_waddr), .ex_result(ex_result),
            .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_result(mem_result),
            .wb_wr_en(wb_wr_en), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
            .rf_data(rf[src_addr[g]]), .value(opnd[g]), .hazard(hz[g])
        );
    end

    assign hazard   = |hz;
    assign stall    = in_valid && hazard;
    // flush also drops in_ready so upstream never sees a handshake that gets discarded
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_wr_en && wb_waddr != '0) begin
            rf[wb_waddr] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_da       <= '0;
            out_db       <= '0;
            out_imm      <= '0;
            out_rn       <= '0;
            out_wr_en    <= 1'b0;
            out_is_load  <= 1'b0;
            out_rs_eq_rt <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_da       <= opnd[0];
            out_db       <= opnd[1];
            out_imm      <= {{(XLEN-16){sext & imm16[15]}}, imm16};
            out_rn       <= rd_or_rt ? rd_addr : rt_addr;
            out_wr_en    <= wr_en_in;
            out_is_load  <= is_load_in;
            out_rs_eq_rt <= (opnd[0] == opnd[1]);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: forwarding, write-through, load-use stall,
// immediate extension, output hold, flush and asynchronous reset.

module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc;
    logic [AW-1:0]   rs_addr, rt_addr, rd_addr;
    logic [15:0]     imm16;
    logic            sext, use_rs, use_rt, rd_or_rt, wr_en_in, is_load_in;
    logic            ex_wr_en, ex_is_load;
    logic [AW-1:0]   ex_waddr;
    logic [XLEN-1:0] ex_result;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_result;
    logic            wb_wr_en;
    logic [AW-1:0]   wb_waddr;
    logic [XLEN-1:0] wb_wdata;
    logic            flush, out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_da, out_db, out_imm;
    logic [AW-1:0]   out_rn;
    logic            out_wr_en, out_is_load, out_rs_eq_rt, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .NREG(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .imm16(imm16), .sext(sext), .use_rs(use_rs), .use_rt(use_rt),
        .rd_or_rt(rd_or_rt), .wr_en_in(wr_en_in), .is_load_in(is_load_in),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
        .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr),
        .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_da(out_da), .out_db(out_db),
        .out_imm(out_imm), .out_rn(out_rn), .out_wr_en(out_wr_en),
        .out_is_load(out_is_load), .out_rs_eq_rt(out_rs_eq_rt), .stall(stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
        imm16 = '0; sext = 0; use_rs = 0; use_rt = 0; rd_or_rt = 0;
        wr_en_in = 0; is_load_in = 0; ex_wr_en = 0; ex_is_load = 0;
        ex_waddr = '0; ex_result = '0; mem_wr_en = 0; mem_waddr = '0;
        mem_result = '0; wb_wr_en = 0; wb_waddr = '0; wb_wdata = '0;
        flush = 0; out_ready = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_da", out_da, 0);
        reset = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // WB write r5, then read it from the register file
        wb_wr_en = 1; wb_waddr = 5; wb_wdata = 32'h1234;
        step();
        wb_wr_en = 0;
        in_valid = 1; rs_addr = 5; use_rs = 1; in_pc = 32'h100;
        rd_addr = 9; rd_or_rt = 1; wr_en_in = 1;
        step();
        chk("rf_out_valid", out_valid, 1);
        chk("rf_out_da", out_da, 32'h1234);
        chk("rf_out_db", out_db, 0);
        chk("rf_out_pc", out_pc, 32'h100);
        chk("rf_out_rn_rd", out_rn, 9);
        chk("rf_out_wr_en", out_wr_en, 1);
        chk("rf_rs_eq_rt", out_rs_eq_rt, 0);

        // same-cycle write-through on both operands, rt selected as destination
        wb_wr_en = 1; wb_waddr = 6; wb_wdata = 32'h55;
        rs_addr = 6; rt_addr = 6; rd_or_rt = 0; is_load_in = 1;
        step();
        chk("wt_out_da", out_da, 32'h55);
        chk("wt_out_db", out_db, 32'h55);
        chk("wt_rs_eq_rt", out_rs_eq_rt, 1);
        chk("wt_out_rn_rt", out_rn, 6);
        chk("wt_out_is_load", out_is_load, 1);

        // EX beats MEM beats WB
        wb_wr_en = 1; wb_waddr = 3; wb_wdata = 32'hCC;
        ex_wr_en = 1; ex_waddr = 3; ex_result = 32'hAA;
        mem_wr_en = 1; mem_waddr = 3; mem_result = 32'hBB;
        rs_addr = 3; rt_addr = 0; is_load_in = 0;
        step();
        chk("fwd_ex", out_da, 32'hAA);
        ex_wr_en = 0;
        step();
        chk("fwd_mem", out_da, 32'hBB);
        mem_wr_en = 0; wb_wdata = 32'hCD;
        step();
        chk("fwd_wb", out_da, 32'hCD);

        // r0 reads zero despite writes and EX targeting it
        wb_wr_en = 1; wb_waddr = 0; wb_wdata = 32'hFFFF;
        ex_wr_en = 1; ex_waddr = 0; ex_result = 32'h77;
        rs_addr = 0;
        step();
        chk("r0_zero", out_da, 0);
        wb_wr_en = 0; ex_wr_en = 0;

        // load-use on rt: stall and bubble
        ex_wr_en = 1; ex_is_load = 1; ex_waddr = 7; ex_result = 32'h99;
        rs_addr = 0; rt_addr = 7; use_rs = 0; use_rt = 0;
        #1;
        chk("lu_unused_stall", stall, 0);
        use_rt = 1;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_bubble", out_valid, 0);
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_waddr = 7; mem_result = 32'hDEAD;
        #1;
        chk("lu_clear_stall", stall, 0);
        chk("lu_clear_ready", in_ready, 1);
        step();
        chk("lu_accept_valid", out_valid, 1);
        chk("lu_mem_fwd", out_db, 32'hDEAD);
        mem_wr_en = 0; use_rt = 0; rt_addr = 0;

        // immediate extension
        imm16 = 16'h8001; sext = 1;
        step();
        chk("imm_sext", out_imm, 32'hFFFF8001);
        sext = 0; in_pc = 32'h200;
        step();
        chk("imm_zext", out_imm, 32'h00008001);

        // hold while downstream is blocked
        out_ready = 0; imm16 = 16'h1234; in_pc = 32'h300;
        #1;
        chk("hold_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_imm", out_imm, 32'h00008001);
            chk("hold_pc", out_pc, 32'h200);
        end
        flush = 1;
        step();
        chk("flush_valid", out_valid, 0);
        // flush wins over an otherwise acceptable instruction
        out_ready = 1;
        step();
        chk("flush_prio", out_valid, 0);
        flush = 0;
        step();
        chk("post_flush_accept", out_valid, 1);
        chk("post_flush_pc", out_pc, 32'h300);

        // asynchronous reset mid-cycle, then r5 must be cleared
        out_ready = 0;
        #2;
        reset = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_pc", out_pc, 0);
        step();
        clear_inputs();
        reset = 0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        in_valid = 1; rs_addr = 5; use_rs = 1;
        step();
        chk("arst_r5_valid", out_valid, 1);
        chk("arst_r5_zero", out_da, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits.
REQ-002 Parameter NREG, default 32: architectural register count, power of two; AW = log2(NREG).
REQ-003 Parameter FWD_EN, default 1: 1 enables EX/MEM/WB forwarding; 0 stalls on every RAW hazard instead.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Ports in_valid in 1, in_ready out 1: upstream handshake.
REQ-007 Ports in_pc in XLEN, rs_addr/rt_addr/rd_addr in AW, imm16 in 16: decoded instruction fields.
REQ-008 Ports sext, use_rs, use_rt, rd_or_rt, wr_en_in, is_load_in in 1: decode flags.
REQ-009 Ports ex_wr_en, ex_is_load in 1; ex_waddr in AW; ex_result in XLEN: EX-stage producer.
REQ-010 Ports mem_wr_en in 1; mem_waddr in AW; mem_result in XLEN: MEM-stage producer, load data included.
REQ-011 Ports wb_wr_en in 1; wb_waddr in AW; wb_wdata in XLEN: register-file write port.
REQ-012 Port flush  in  1  discards the instruction currently held in the output register.
REQ-013 Ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-014 Ports out_pc, out_da, out_db, out_imm out XLEN; out_rn out AW; out_wr_en, out_is_load, out_rs_eq_rt out 1.
REQ-015 Port stall  out  1  high while a hazard blocks acceptance.

Function
REQ-016 Register file SHALL hold NREG x XLEN entries; register 0 SHALL read as 0 and ignore writes.
REQ-017 Writes occur on the rising edge when wb_wr_en=1; a same-cycle read of wb_waddr SHALL return wb_wdata (write-through).
REQ-018 Forward priority for each operand, FWD_EN=1: EX (ex_wr_en, not ex_is_load, address match, nonzero) > MEM > WB > register file.
REQ-019 Hazard SHALL assert when the operand is used (use_rs/use_rt), its address is nonzero, ex_wr_en=1, ex_is_load=1 and the address matches ex_waddr (load-use).
REQ-020 With FWD_EN=0, hazard SHALL also assert on any used-operand match against an EX, MEM or WB pending write.
REQ-021 stall = in_valid AND hazard; in_ready = NOT hazard AND (NOT out_valid OR out_ready).
REQ-022 An instruction is accepted when in_valid AND in_ready; it is captured into the output register on that edge. Latency: 1 cycle.
REQ-023 out_imm SHALL be imm16 sign-extended when sext=1, otherwise zero-extended, to XLEN.
REQ-024 out_rn SHALL be rd_addr when rd_or_rt=1, otherwise rt_addr.
REQ-025 out_rs_eq_rt SHALL compare the two forwarded operand values, registered with the instruction.
REQ-026 out_valid: set on accept; cleared when out_ready=1 with no new accept; held with all outputs stable while out_valid=1 and out_ready=0.
REQ-027 flush=1 SHALL clear out_valid on the next edge and block acceptance that cycle; flush takes priority over accept.
REQ-028 A stalled instruction is not captured; on a stall cycle with out_ready=1, out_valid SHALL drop to 0 (bubble inserted).

Reset
REQ-029 Reset SHALL asynchronously clear out_valid, out_wr_en, out_is_load, out_rs_eq_rt and all data outputs to 0.
REQ-030 Reset SHALL clear all register-file entries to 0; an in-flight instruction is discarded; in_ready SHALL be 1 after release.

Verification
REQ-031 Write r5=0x1234 via WB, then issue rs=5 with no EX/MEM match -> out_da=0x00001234 one cycle later.
REQ-032 ex_wr_en=1, ex_waddr=3, ex_result=0xAA; mem_waddr=3, mem_result=0xBB; issue rs=3 -> out_da=0xAA.
REQ-033 ex_is_load=1, ex_waddr=7; issue rt=7, use_rt=1 -> stall=1, in_ready=0, out_valid=0 next cycle; load clears -> accept with MEM-forwarded value.
REQ-034 imm16=0x8001, sext=1 -> out_imm=0xFFFF8001; sext=0 -> 0x00008001.
REQ-035 out_valid=1, out_ready=0 for 3 cycles -> outputs unchanged; then flush=1 -> out_valid=0 next edge.
REQ-036 Assert reset mid-transfer with out_valid=1 -> out_valid=0 immediately; read of r5 after release returns 0.
